// File: rtl/stereolbm_mul_pipe.sv
// -----------------------------------------------------------------------------
// stereolbm_mul_pipe
//
// Valid-tracked pipelined multiplier for the stereo LBM datapath. It extends
// each operand by one bit (sign or zero), forms the exact product, optionally
// applies a round-half-up arithmetic right shift, and reduces the result to
// dout_WIDTH. The reduction either wraps or saturates. The reduced result and
// the valid bit then pass through NUM_STAGE clock-enabled registers.
//
// Optional feature macro:
//   STEREOLBM_MUL_SAT_EN - saturate out-of-range results to the nearest bound
//                          and raise sat_flag. When undefined, the result wraps
//                          and sat_flag is tied to 0.
//
// Parameters:
//   NUM_STAGE  (1..4)  register stages from input to dout
//   din0_WIDTH         operand 0 width
//   din1_WIDTH         operand 1 width
//   dout_WIDTH         result width
//   SIGNED0/SIGNED1    1 = operand is two's complement, 0 = unsigned
//   SHIFT              rounding right-shift (0..din0_WIDTH+din1_WIDTH-1)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset; clears every stage
//   ce          clock enable; when 0, all pipeline state holds
//   din_valid   qualifies din0/din1
//   din0, din1  operands
//   dout        scaled result, registered
//   dout_valid  dout holds a valid result
//   sat_flag    the result on dout was clipped
// -----------------------------------------------------------------------------
module stereolbm_mul_pipe #(
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 26,
   parameter int SIGNED0    = 1,
   parameter int SIGNED1    = 1,
   parameter int SHIFT      = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  din_valid,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  sat_flag
);

   // Product of two (width+1)-bit signed operands is exact at this width.
   localparam int W          = din0_WIDTH + din1_WIDTH + 2;
   localparam int DW         = dout_WIDTH;
   localparam bit OUT_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);

   logic                ext0_msb;
   logic                ext1_msb;
   logic signed [W-1:0] op0;
   logic signed [W-1:0] op1;
   logic signed [W-1:0] prod;
   logic signed [W-1:0] res;
   logic [DW-1:0]       red_data;

   // One extra bit per operand lets unsigned and signed operands share a
   // single signed multiplier.
   assign ext0_msb = (SIGNED0 != 0) ? din0[din0_WIDTH-1] : 1'b0;
   assign ext1_msb = (SIGNED1 != 0) ? din1[din1_WIDTH-1] : 1'b0;
   assign op0      = W'($signed({ext0_msb, din0}));
   assign op1      = W'($signed({ext1_msb, din1}));
   assign prod     = op0 * op1;

   generate
      if (SHIFT > 0) begin : g_round
         // Adding half an LSB before the arithmetic shift rounds half toward
         // +infinity, including for negative products.
         localparam logic signed [W-1:0] HALF = W'(1) << (SHIFT - 1);
         assign res = (prod + HALF) >>> SHIFT;
      end else begin : g_no_round
         assign res = prod;
      end
   endgenerate

`ifdef STEREOLBM_MUL_SAT_EN
   logic red_sat;

   generate
      if (DW >= W) begin : g_no_clip
         // Every result fits; extension is lossless.
         assign red_sat  = 1'b0;
         assign red_data = DW'(res);
      end else if (OUT_SIGNED) begin : g_clip_signed
         // In range only when all bits from the output sign bit upward agree.
         logic ovf;
         assign ovf      = (res[W-1:DW-1] != {(W-DW+1){res[W-1]}});
         assign red_sat  = ovf;
         assign red_data = ovf ? {res[W-1], {(DW-1){~res[W-1]}}} : DW'(res);
      end else begin : g_clip_unsigned
         // Unsigned x unsigned never goes negative, so only the top bound
         // can be crossed.
         logic ovf;
         assign ovf      = |res[W-1:DW];
         assign red_sat  = ovf;
         assign red_data = ovf ? {DW{1'b1}} : DW'(res);
      end
   endgenerate
`else
   // Plain truncation: the result wraps on overflow.
   assign red_data = DW'(res);
`endif

   logic [DW-1:0] data_q [NUM_STAGE];
   logic          vld_q  [NUM_STAGE];

   // NOTE: sequential state uses non-blocking assignments so that every stage
   // samples its predecessor's value from before the edge, not after it.
   // NOTE: the stage registers are plain flops and reset in full, so that
   // in-flight beats are discarded and dout reads 0 during reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_STAGE; i++) begin
            data_q[i] <= '0;
            vld_q[i]  <= 1'b0;
         end
      end else if (ce) begin
         data_q[0] <= red_data;
         vld_q[0]  <= din_valid;
         for (int i = 1; i < NUM_STAGE; i++) begin
            data_q[i] <= data_q[i-1];
            vld_q[i]  <= vld_q[i-1];
         end
      end
   end

   assign dout       = data_q[NUM_STAGE-1];
   assign dout_valid = vld_q[NUM_STAGE-1];

`ifdef STEREOLBM_MUL_SAT_EN
   logic sat_q [NUM_STAGE];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_STAGE; i++) begin
            sat_q[i] <= 1'b0;
         end
      end else if (ce) begin
         sat_q[0] <= red_sat;
         for (int i = 1; i < NUM_STAGE; i++) begin
            sat_q[i] <= sat_q[i-1];
         end
      end
   end

   assign sat_flag = sat_q[NUM_STAGE-1];
`else
   assign sat_flag = 1'b0;
`endif

endmodule
